// File: rtl/td4_core_hs.sv
// rtl/td4_core_hs.sv - TD4-compatible core with handshaked instruction fetch, run gating and halt
module td4_core_hs #(
    parameter int                DATA_W   = 4,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W+3:0] mem_data,
    output logic              carry,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD_A = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A  = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B = 4'b0101;
    localparam logic [3:0] OP_IN_B  = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_OUT_B = 4'b1001;
    localparam logic [3:0] OP_OUT_I = 4'b1011;
    localparam logic [3:0] OP_HLT   = 4'b1101;
    localparam logic [3:0] OP_JNC   = 4'b1110;
    localparam logic [3:0] OP_JMP   = 4'b1111;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic                carry_q, carry_d;
    logic [DATA_W+3:0]   ir_q, ir_d;

    logic [3:0]          opcode;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   src;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   pc_inc;

    assign opcode = ir_q[DATA_W+3:DATA_W];
    assign imm    = ir_q[DATA_W-1:0];
    assign pc_inc = pc_q + {{(DATA_W-1){1'b0}}, 1'b1};

    // ALU source operand; immediate-only, jump and NOP opcodes add to zero so carry clears
    always_comb begin
        src = '0;
        case (opcode)
            OP_ADD_A, OP_MOV_BA:           src = a_q;
            OP_MOV_AB, OP_ADD_B, OP_OUT_B: src = b_q;
            OP_IN_A, OP_IN_B:              src = in;
            default:                       src = '0;
        endcase
    end

    assign sum = {1'b0, src} + {1'b0, imm};

    // Next-state and commit logic for the fetch/execute/halt sequencer
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        pc_d    = pc_q;
        carry_d = carry_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: begin
                if (run && mem_ack) begin
                    ir_d    = mem_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (opcode == OP_HLT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    carry_d = sum[DATA_W];
                    pc_d    = pc_inc;
                    case (opcode)
                        OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_AI: a_d   = sum[DATA_W-1:0];
                        OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_BI: b_d   = sum[DATA_W-1:0];
                        OP_OUT_B, OP_OUT_I:                      out_d = sum[DATA_W-1:0];
                        OP_JMP:                                  pc_d  = imm;
                        OP_JNC:                                  pc_d  = carry_q ? pc_inc : imm;
                        default:                                 ;
                    endcase
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Architectural state registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            pc_q    <= RESET_PC;
            carry_q <= 1'b0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            pc_q    <= pc_d;
            carry_q <= carry_d;
            ir_q    <= ir_d;
        end
    end

    assign mem_req  = (state_q == S_FETCH) && run;
    assign mem_addr = pc_q;
    assign halted   = (state_q == S_HALT);
    assign out      = out_q;
    assign carry    = carry_q;

endmodule

// File: tb/tb_td4_core_hs.sv
// tb/tb_td4_core_hs.sv - randomized and directed checks of td4_core_hs against an instruction-level model
module tb_td4_core_hs;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit core
    logic        rst_n4, run4, mem_ack4, mem_req4, carry4, halted4;
    logic [3:0]  in4, out4, mem_addr4;
    logic [7:0]  mem_data4;

    // 8-bit core with relocated reset vector, zero-wait memory
    logic        rst_n8, run8, mem_req8, carry8, halted8;
    logic [7:0]  in8, out8, mem_addr8;
    logic [11:0] mem_data8;
    logic        mem_ack8;
    logic [11:0] prog8 [256];

    assign mem_ack8  = mem_req8;
    assign mem_data8 = prog8[mem_addr8];

    td4_core_hs #(.DATA_W(4), .RESET_PC(4'h0)) dut4 (
        .clk(clk), .rst_n(rst_n4), .run(run4), .in(in4), .out(out4),
        .mem_req(mem_req4), .mem_addr(mem_addr4), .mem_ack(mem_ack4),
        .mem_data(mem_data4), .carry(carry4), .halted(halted4)
    );

    td4_core_hs #(.DATA_W(8), .RESET_PC(8'h80)) dut8 (
        .clk(clk), .rst_n(rst_n8), .run(run8), .in(in8), .out(out8),
        .mem_req(mem_req8), .mem_addr(mem_addr8), .mem_ack(mem_ack8),
        .mem_data(mem_data8), .carry(carry8), .halted(halted8)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Instruction-level reference model of the 4-bit machine
    logic [7:0] prog4 [16];
    int m_a, m_b, m_out, m_pc, m_carry, m_halt;
    int in_fix = -1;

    task automatic model_reset();
        m_a = 0; m_b = 0; m_out = 0; m_pc = 0; m_carry = 0; m_halt = 0;
    endtask

    task automatic model_step(input logic [7:0] ins, input int inv);
        int op, imm, s, npc;
        op  = int'(ins[7:4]);
        imm = int'(ins[3:0]);
        npc = (m_pc + 1) % 16;
        s   = 0;
        case (op)
            0:  begin s = m_a + imm;  m_a   = s % 16; end
            1:  begin s = m_b + imm;  m_a   = s % 16; end
            2:  begin s = inv + imm;  m_a   = s % 16; end
            3:  begin s = imm;        m_a   = s;      end
            4:  begin s = m_a + imm;  m_b   = s % 16; end
            5:  begin s = m_b + imm;  m_b   = s % 16; end
            6:  begin s = inv + imm;  m_b   = s % 16; end
            7:  begin s = imm;        m_b   = s;      end
            9:  begin s = m_b + imm;  m_out = s % 16; end
            11: begin s = imm;        m_out = s;      end
            13: m_halt = 1;
            14: npc = (m_carry != 0) ? npc : imm;
            15: npc = imm;
            default: s = 0;
        endcase
        if (m_halt == 0) begin
            m_carry = (s > 15) ? 1 : 0;
            m_pc    = npc;
        end
    endtask

    task automatic reset4();
        @(negedge clk);
        run4 = 1'b0; mem_ack4 = 1'b0; rst_n4 = 1'b0;
        #1;
        chk("rst_out", 32'(out4), 0);
        chk("rst_carry", 32'(carry4), 0);
        chk("rst_halted", 32'(halted4), 0);
        chk("rst_req", 32'(mem_req4), 0);
        chk("rst_addr", 32'(mem_addr4), 0);
        @(negedge clk);
        rst_n4 = 1'b1;
        model_reset();
    endtask

    // One fetch with lat wait cycles (optional RUN drop with a spurious ack) followed by EXEC
    task automatic fetch_exec(input int lat, input bit stall);
        logic [7:0] ins;
        int inv;
        run4 = 1'b1;
        #1;
        chk("req_on", 32'(mem_req4), 1);
        chk("addr", 32'(mem_addr4), 32'(m_pc));
        for (int i = 0; i < lat; i++) begin
            @(posedge clk); @(negedge clk);
            if (stall && i == 0) begin
                run4 = 1'b0; mem_ack4 = 1'b1; mem_data4 = 8'hF5;
                #1;
                chk("req_stall", 32'(mem_req4), 0);
                @(posedge clk); @(negedge clk);
                mem_ack4 = 1'b0; run4 = 1'b1;
                #1;
            end
            chk("req_hold", 32'(mem_req4), 1);
            chk("addr_hold", 32'(mem_addr4), 32'(m_pc));
        end
        ins = prog4[m_pc];
        mem_ack4 = 1'b1; mem_data4 = ins;
        @(posedge clk); @(negedge clk);
        mem_ack4  = 1'b0;
        mem_data4 = 8'($urandom);
        inv = (in_fix >= 0) ? in_fix : int'($urandom_range(15, 0));
        in4 = 4'(inv);
        #1;
        chk("req_exec", 32'(mem_req4), 0);
        @(posedge clk); @(negedge clk);
        model_step(ins, inv);
        chk("out", 32'(out4), 32'(m_out));
        chk("carry", 32'(carry4), 32'(m_carry));
        chk("halted", 32'(halted4), 32'(m_halt));
        chk("pc", 32'(mem_addr4), 32'(m_pc));
    endtask

    task automatic run_prog(input int max_steps, input int max_lat, input bit allow_stall);
        int lat;
        bit st;
        for (int k = 0; k < max_steps && m_halt == 0; k++) begin
            lat = int'($urandom_range(max_lat, 0));
            st  = allow_stall && (lat > 0) && ($urandom_range(3, 0) == 0);
            fetch_exec(lat, st);
        end
        if (m_halt != 0) begin
            run4 = 1'b1; mem_ack4 = 1'b1;
            repeat (3) begin @(posedge clk); @(negedge clk); end
            mem_ack4 = 1'b0;
            chk("halt_req", 32'(mem_req4), 0);
            chk("halt_hold", 32'(halted4), 1);
            chk("halt_out", 32'(out4), 32'(m_out));
            chk("halt_carry", 32'(carry4), 32'(m_carry));
            chk("halt_pc", 32'(mem_addr4), 32'(m_pc));
        end
    endtask

    task automatic load4(input logic [63:0] words, input int n);
        logic [63:0] w;
        w = words;
        for (int i = 0; i < 16; i++) prog4[i] = 8'hD0;
        for (int i = 0; i < n; i++) prog4[i] = w[8*(n-1-i) +: 8];
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n4 = 1'b0; run4 = 1'b0; mem_ack4 = 1'b0; mem_data4 = '0; in4 = '0;
        rst_n8 = 1'b0; run8 = 1'b0; in8 = '0;
        for (int i = 0; i < 256; i++) prog8[i] = 12'hD00;
        model_reset();
        repeat (2) @(negedge clk);

        // Zero-wait memory: MOV A,7; ADD A,10; HLT
        load4(64'h37_0A_D0, 3);
        reset4();
        for (int k = 0; k < 3; k++) fetch_exec(0, 1'b0);
        chk("t1_carry", 32'(carry4), 1);
        chk("t1_halted", 32'(halted4), 1);
        run_prog(1, 0, 1'b0);

        // Same program with a three-cycle ack delay
        reset4();
        for (int k = 0; k < 3; k++) fetch_exec(3, 1'b0);
        chk("t2_carry", 32'(carry4), 1);

        // Carry loop terminates via JNC, OUT Im clears carry
        load4(64'h01_E0_BF_D0, 4);
        reset4();
        run_prog(60, 1, 1'b0);
        chk("t3_out", 32'(out4), 15);
        chk("t3_carry", 32'(carry4), 0);
        chk("t3_halted", 32'(halted4), 1);

        // PC wrap through NOPs, with a forced RUN drop during a wait
        for (int i = 0; i < 16; i++) prog4[i] = (i % 3 == 0) ? 8'h85 : ((i % 3 == 1) ? 8'hAF : 8'hC3);
        reset4();
        for (int k = 0; k < 16; k++) fetch_exec(k % 3, 1'b0);
        chk("t4_wrap", 32'(mem_addr4), 0);
        fetch_exec(2, 1'b1);

        // IN path with fixed input
        load4(64'h23_40_90_D0, 4);
        in_fix = 9;
        reset4();
        run_prog(10, 2, 1'b1);
        chk("t5_out", 32'(out4), 12);
        chk("t5_carry", 32'(carry4), 0);
        in_fix = -1;

        // Random programs, random latencies and stalls
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 16; i++) prog4[i] = 8'($urandom);
            reset4();
            run_prog(40, 3, 1'b1);
        end

        // 8-bit core: relocated reset vector, wide add carry, async reset in EXEC
        prog8[8'h80] = 12'h3_02;
        prog8[8'h81] = 12'h0_FF;
        prog8[8'h82] = 12'h4_00;
        prog8[8'h83] = 12'h9_00;
        prog8[8'h84] = 12'h0_FF;
        prog8[8'h85] = 12'h0_00;
        @(negedge clk);
        rst_n8 = 1'b1; run8 = 1'b1;
        #1;
        chk("w_first_addr", 32'(mem_addr8), 32'h80);
        chk("w_first_req", 32'(mem_req8), 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("w_add_carry", 32'(carry8), 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("w_out", 32'(out8), 1);
        chk("w_mov_carry", 32'(carry8), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("w_carry2", 32'(carry8), 1);
        @(posedge clk);
        @(negedge clk);
        rst_n8 = 1'b0; run8 = 1'b0;
        #1;
        chk("w_rst_out", 32'(out8), 0);
        chk("w_rst_carry", 32'(carry8), 0);
        chk("w_rst_addr", 32'(mem_addr8), 32'h80);
        chk("w_rst_req", 32'(mem_req8), 0);
        chk("w_rst_halted", 32'(halted8), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
